// File: rtl/vga_axi_mem_wr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_axi_mem_wr
// Brief    : AXI4-Lite write slave for the VGA frame memory; one AW/W/B
//            transaction at a time, single-cycle write strobe to the RAM.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axi_mem_wr #(
    parameter  int AXI_ADDR_WIDTH = 32,
    parameter  int AXI_DATA_WIDTH = 64,
    parameter  int MEM_DEPTH      = 4096,
    localparam int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                          s_aclk_i,
    input  logic                          s_arstn_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_awaddr_i,
    input  logic [2:0]                    s_awprot_i,
    input  logic                          s_awvalid_i,
    output logic                          s_awrdy_o,
    input  logic [AXI_DATA_WIDTH-1:0]     s_wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_wstrb_i,
    input  logic                          s_wvalid_i,
    output logic                          s_wrdy_o,
    output logic [1:0]                    s_bresp_o,
    output logic                          s_bvalid_o,
    input  logic                          s_brdy_i,
    output logic                          mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [AXI_DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   mem_wstrb_o
);

    localparam int c_STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int c_ADDR_LSB   = $clog2(c_STRB_WIDTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] c_MEM_DEPTH = AXI_ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WRITE = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;

    logic [1:0]                r_state;
    logic                      r_aw_held;
    logic                      r_w_held;
    logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [c_STRB_WIDTH-1:0]   r_wstrb;
    logic                      r_awrdy;
    logic                      r_wrdy;
    logic                      r_bvalid;
    logic [1:0]                r_bresp;
    logic                      r_mem_we;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
    logic [AXI_DATA_WIDTH-1:0] r_mem_wdata;
    logic [c_STRB_WIDTH-1:0]   r_mem_wstrb;

    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_aw_have;
    logic                      w_w_have;
    logic [AXI_ADDR_WIDTH-1:0] w_word_idx;
    logic                      w_in_range;
    logic                      w_do_write;
    logic [2:0]                w_unused_prot;

    // Readies are only ever high in IDLE, so they gate the handshakes alone.
    assign w_aw_hs       = s_awvalid_i & r_awrdy;
    assign w_w_hs        = s_wvalid_i & r_wrdy;
    assign w_aw_have     = r_aw_held | w_aw_hs;
    assign w_w_have      = r_w_held | w_w_hs;
    assign w_word_idx    = r_awaddr >> c_ADDR_LSB;
    assign w_in_range    = (w_word_idx < c_MEM_DEPTH);
    assign w_do_write    = w_in_range & (|r_wstrb);
    assign w_unused_prot = s_awprot_i;

    always_ff @(posedge s_aclk_i) begin
        if (!s_arstn_i) begin
            r_state     <= c_ST_IDLE;
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awrdy     <= 1'b0;
            r_wrdy      <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= c_RESP_OKAY;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr  <= s_awaddr_i;
                        r_aw_held <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= s_wdata_i;
                        r_wstrb  <= s_wstrb_i;
                        r_w_held <= 1'b1;
                    end
                    r_awrdy <= ~w_aw_have;
                    r_wrdy  <= ~w_w_have;
                    if (w_aw_have && w_w_have) begin
                        r_state <= c_ST_WRITE;
                    end
                end
                c_ST_WRITE: begin
                    r_mem_we <= w_do_write;
                    if (w_do_write) begin
                        r_mem_addr  <= w_word_idx[MEM_ADDR_WIDTH-1:0];
                        r_mem_wdata <= r_wdata;
                        r_mem_wstrb <= r_wstrb;
                    end
                    r_bresp <= w_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
                    r_state <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    // First RESP cycle raises bvalid; it then holds until accepted.
                    if (!r_bvalid) begin
                        r_bvalid <= 1'b1;
                    end else if (s_brdy_i) begin
                        r_bvalid  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awrdy   <= 1'b1;
                        r_wrdy    <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign s_awrdy_o   = r_awrdy;
    assign s_wrdy_o    = r_wrdy;
    assign s_bvalid_o  = r_bvalid;
    assign s_bresp_o   = r_bresp;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_wstrb_o = r_mem_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_vga_axi_mem_wr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_axi_mem_wr
// Brief    : Self-checking bench for vga_axi_mem_wr against a timestamp-based
//            transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_axi_mem_wr;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awrdy;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wrdy;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        brdy;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;

    always #5 clk = ~clk;

    vga_axi_mem_wr #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (64),
        .MEM_DEPTH      (4096)
    ) u_dut (
        .s_aclk_i    (clk),
        .s_arstn_i   (rstn),
        .s_awaddr_i  (awaddr),
        .s_awprot_i  (awprot),
        .s_awvalid_i (awvalid),
        .s_awrdy_o   (awrdy),
        .s_wdata_i   (wdata),
        .s_wstrb_i   (wstrb),
        .s_wvalid_i  (wvalid),
        .s_wrdy_o    (wrdy),
        .s_bresp_o   (bresp),
        .s_bvalid_o  (bvalid),
        .s_brdy_i    (brdy),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_wstrb_o (mem_wstrb)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n       = 0;

    always @(posedge clk) n <= n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %h, expected %h", name, n, act, exp);
        end
    endtask

    // Model: a transaction is accepted at edge m_acc; the write shows after
    // edge m_acc+1, bvalid from edge m_acc+2 until the B handshake edge.
    bit          m_valid = 0;
    bit          m_rst_next = 1;
    bit          m_rst_now;
    bit          m_busy, m_aw_have, m_w_have, m_wr_ok;
    int          m_acc;
    logic [31:0] m_addr, m_idx;
    logic [63:0] m_data;
    logic [7:0]  m_strb;
    logic [1:0]  m_resp;
    logic [11:0] m_last_addr;
    logic [63:0] m_last_data;
    logic [7:0]  m_last_strb;
    bit          e_awrdy, e_wrdy, e_we, e_bvalid;

    logic [11:0] q_wr_addr[$];
    logic [63:0] q_wr_data[$];
    logic [7:0]  q_wr_strb[$];
    int          q_wr_cyc[$];
    logic [1:0]  q_resp[$];
    int          bv_cnt;
    int          bv_first;

    always @(negedge clk) begin
        m_rst_now = m_rst_next;
        if (m_rst_now) begin
            m_valid = 1; m_busy = 0; m_aw_have = 0; m_w_have = 0;
            m_last_addr = '0; m_last_data = '0; m_last_strb = '0;
        end
        if (m_valid) begin
            if (!m_rst_now && m_busy && n == m_acc + 1 && m_wr_ok) begin
                m_last_addr = m_idx[11:0];
                m_last_data = m_data;
                m_last_strb = m_strb;
            end
            e_awrdy  = !m_rst_now && !m_busy && !m_aw_have;
            e_wrdy   = !m_rst_now && !m_busy && !m_w_have;
            e_we     = !m_rst_now && m_busy && (n == m_acc + 1) && m_wr_ok;
            e_bvalid = !m_rst_now && m_busy && (n >= m_acc + 2);
            chk("awrdy", 64'(awrdy), 64'(e_awrdy));
            chk("wrdy", 64'(wrdy), 64'(e_wrdy));
            chk("mem_we", 64'(mem_we), 64'(e_we));
            chk("bvalid", 64'(bvalid), 64'(e_bvalid));
            chk("mem_addr", 64'(mem_addr), 64'(m_last_addr));
            chk("mem_wdata", mem_wdata, m_last_data);
            chk("mem_wstrb", 64'(mem_wstrb), 64'(m_last_strb));
            if (e_bvalid) chk("bresp", 64'(bresp), 64'(m_resp));
            if (m_rst_now) chk("bresp_rst", 64'(bresp), 64'd0);

            if (mem_we === 1'b1) begin
                q_wr_addr.push_back(mem_addr);
                q_wr_data.push_back(mem_wdata);
                q_wr_strb.push_back(mem_wstrb);
                q_wr_cyc.push_back(n);
            end
            if (bvalid === 1'b1) begin
                bv_cnt++;
                if (bv_first < 0) bv_first = n;
                if (brdy) q_resp.push_back(bresp);
            end

            m_rst_next = !rstn;
            if (!m_rst_next) begin
                if (e_bvalid && brdy) begin
                    m_busy = 0; m_aw_have = 0; m_w_have = 0;
                end else if (!m_busy) begin
                    if (awvalid && e_awrdy) begin m_aw_have = 1; m_addr = awaddr; end
                    if (wvalid && e_wrdy) begin m_w_have = 1; m_data = wdata; m_strb = wstrb; end
                    if (m_aw_have && m_w_have) begin
                        m_busy  = 1;
                        m_acc   = n + 1;
                        m_idx   = m_addr / 8;
                        m_wr_ok = (m_idx < 4096) && (m_strb != 8'h00);
                        m_resp  = (m_idx < 4096) ? 2'b00 : 2'b10;
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        q_wr_addr.delete(); q_wr_data.delete(); q_wr_strb.delete();
        q_wr_cyc.delete(); q_resp.delete();
        bv_cnt = 0; bv_first = -1;
    endtask

    task automatic xfer(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                        input int ad, input int wd, input int bd, input bit abort);
        int c; bit a_done; bit w_done; bit b_done; int bcnt;
        c = 0; a_done = 0; w_done = 0; b_done = 0; bcnt = 0;
        awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom);
        while (!b_done && c < 80) begin
            awvalid = !a_done && (c >= ad);
            wvalid  = !w_done && (c >= wd);
            brdy    = !abort && (bcnt >= bd);
            @(negedge clk);
            if (awvalid && awrdy) a_done = 1;
            if (wvalid && wrdy) w_done = 1;
            if (bvalid) begin
                if (brdy || abort) b_done = 1;
                else bcnt++;
            end
            @(posedge clk); #1;
            c++;
        end
        awvalid = 0; wvalid = 0; brdy = 0;
        n_tests++;
        if (!b_done) begin
            n_fail++;
            $display("FAIL xfer_timeout addr=%h: got no B response, expected one within 80 cycles", a);
        end
    endtask

    initial begin
        logic [31:0] ba[10];
        logic [63:0] d;
        int t0;
        bv_first = -1;
        rstn = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; brdy = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_awrdy", 64'(awrdy), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        @(posedge clk); #1;
        rstn = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_rst", 64'({awrdy, wrdy}), 64'h3);
        @(posedge clk); #1;

        // Aligned, same-cycle AW/W
        clear_logs();
        t0 = n;
        xfer(32'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0, 0, 0);
        chk("t1_count", 64'(q_wr_addr.size()), 64'd1);
        chk("t1_addr", 64'(q_wr_addr[0]), 64'd2);
        chk("t1_data", q_wr_data[0], 64'hDEADBEEF_CAFEF00D);
        chk("t1_strb", 64'(q_wr_strb[0]), 64'hFF);
        chk("t1_we_time", 64'(q_wr_cyc[0] - t0), 64'd2);
        chk("t1_bv_time", 64'(bv_first - t0), 64'd3);
        chk("t1_resp", 64'(q_resp[0]), 64'd0);

        // W before AW with B backpressure
        clear_logs();
        xfer(32'h1238, 64'h0123_4567_89AB_CDEF, 8'hFF, 4, 0, 5, 0);
        chk("t2_count", 64'(q_wr_addr.size()), 64'd1);
        chk("t2_addr", 64'(q_wr_addr[0]), 64'h247);
        chk("t2_bv_cycles", 64'(bv_cnt), 64'd6);
        chk("t2_resp", 64'(q_resp[0]), 64'd0);

        // Out of range
        clear_logs();
        xfer(32'h8000, 64'h1111_2222_3333_4444, 8'hFF, 0, 0, 0, 0);
        chk("t3_nowrite", 64'(q_wr_addr.size()), 64'd0);
        chk("t3_resp", 64'(q_resp[0]), 64'h2);

        // Partial, zero strobes and unaligned address
        clear_logs();
        xfer(32'h20, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 0, 0, 0, 0);
        chk("t4_strb", 64'(q_wr_strb[0]), 64'h0F);
        chk("t4_addr", 64'(q_wr_addr[0]), 64'd4);
        clear_logs();
        xfer(32'h28, 64'h5555_6666_7777_8888, 8'h00, 0, 0, 0, 0);
        chk("t4_zero_nowrite", 64'(q_wr_addr.size()), 64'd0);
        chk("t4_zero_resp", 64'(q_resp[0]), 64'd0);
        clear_logs();
        xfer(32'h13, 64'h9999_AAAA_BBBB_CCCC, 8'hFF, 0, 0, 0, 0);
        chk("t4_unaligned", 64'(q_wr_addr[0]), 64'd2);

        // Reset while bvalid is high
        xfer(32'h40, 64'hFEED_FACE_0000_0001, 8'hFF, 0, 0, 0, 1);
        clear_logs();
        rstn = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_bvalid_rst", 64'(bvalid), 64'd0);
        chk("t5_ready_rst", 64'({awrdy, wrdy}), 64'd0);
        @(posedge clk); #1;
        rstn = 1;
        @(posedge clk); #1;
        xfer(32'h0, 64'h0BAD_F00D_1234_5678, 8'hFF, 0, 0, 0, 0);
        chk("t5_count", 64'(q_wr_addr.size()), 64'd1);
        chk("t5_addr", 64'(q_wr_addr[0]), 64'd0);
        chk("t5_data", q_wr_data[0], 64'h0BAD_F00D_1234_5678);

        // Back-to-back in-range writes
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            ba[i] = $urandom_range(0, 32'h7FFF);
            d = {$urandom, $urandom};
            xfer(ba[i], d, 8'hFF, 0, 0, 0, 0);
        end
        chk("t6_count", 64'(q_wr_addr.size()), 64'd10);
        for (int i = 0; i < 10 && i < q_wr_addr.size(); i++) begin
            chk("t6_addr", 64'(q_wr_addr[i]), 64'(ba[i] >> 3));
            chk("t6_resp", 64'(q_resp[i]), 64'd0);
            if (i > 0) chk("t6_spacing", 64'(q_wr_cyc[i] - q_wr_cyc[i-1]), 64'd4);
        end

        // Random mix of order, delays, range and strobes
        for (int i = 0; i < 25; i++) begin
            d = {$urandom, $urandom};
            xfer($urandom_range(0, 32'h9000), d,
                 ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_axi_mem_wr.md
# vga_axi_mem_wr

AXI4-Lite write-channel slave for the VGA frame memory: the write-side counterpart of the existing read-channel slave. It accepts AW/W/B transactions from a host-side master, translates the byte address to a memory word index, and issues a single-cycle write strobe to the frame-buffer write port. The block handles one transaction at a time and sits between the system interconnect and the frame-buffer RAM.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 32, AXI address width
- AXI_DATA_WIDTH, 64, AXI data width (power of two, ≥ 8)
- MEM_DEPTH, 4096, number of AXI_DATA_WIDTH-wide words in the frame memory; MEM_ADDR_WIDTH = $clog2(MEM_DEPTH) (derived)

Ports (one clock; reset is synchronous and active-low):
- s_aclk_i  in  1  clock
- s_arstn_i  in  1  synchronous active-low reset
- s_awaddr_i  in  AXI_ADDR_WIDTH  write byte address
- s_awprot_i  in  3  protection, ignored
- s_awvalid_i  in  1  AW valid
- s_awrdy_o  out  1  AW ready
- s_wdata_i  in  AXI_DATA_WIDTH  write data
- s_wstrb_i  in  AXI_DATA_WIDTH/8  byte strobes
- s_wvalid_i  in  1  W valid
- s_wrdy_o  out  1  W ready
- s_bresp_o  out  2  write response (00 OKAY, 10 SLVERR)
- s_bvalid_o  out  1  B valid
- s_brdy_i  in  1  B ready
- mem_we_o  out  1  memory write enable, one-cycle pulse
- mem_addr_o  out  MEM_ADDR_WIDTH  memory word index
- mem_wdata_o  out  AXI_DATA_WIDTH  memory write data
- mem_wstrb_o  out  AXI_DATA_WIDTH/8  memory byte enables

## Operation
- States: IDLE, WRITE, RESP. All outputs registered.
- IDLE: s_awrdy_o = 1 while no AW is held; s_wrdy_o = 1 while no W is held. AW and W are accepted independently, in either order or in the same cycle. On each handshake (valid & rdy at an edge), capture the payload into a holding register, set its held flag, and deassert the matching ready on that edge.
- On the edge where the second of the two payloads is held (or both in the same cycle): go to WRITE.
- WRITE (one cycle): word index = s_awaddr >> $clog2(AXI_DATA_WIDTH/8); the low address bits are ignored, so unaligned addresses round down. If index < MEM_DEPTH and wstrb ≠ 0: mem_we_o = 1, with mem_addr_o, mem_wdata_o and mem_wstrb_o driven from the held values. Response is OKAY if index < MEM_DEPTH, otherwise SLVERR, with no memory write. Zero strobes give OKAY with no write. Next state is RESP.
- RESP: s_bvalid_o = 1, s_bresp_o stable until s_brdy_i. On the B handshake: clear the held flags, go to IDLE, and reassert both readies on that same edge.
- Readies stay 0 in WRITE and RESP. No new AW/W is accepted until the B handshake.
- s_awprot_i is ignored.

## Timing
- Reset values: s_awrdy_o = 0, s_wrdy_o = 0, s_bvalid_o = 0, s_bresp_o = 00, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, mem_wstrb_o = 0. The state is IDLE and the held flags are clear.
- Both readies rise on the first edge with s_arstn_i = 1.
- AW and W handshakes at the same edge E: mem_we_o is high in cycle E+1 only, and s_bvalid_o is high from edge E+2.
- AW at edge E1 and W at a later edge E2: the write cycle is E2+1. The reverse order is symmetric.
- With s_brdy_i held high, s_bvalid_o is high for one cycle. Minimum transaction period is 4 cycles (accept, write, resp, ready back).
- s_bvalid_o never drops without s_brdy_i, except on reset.
- Reset asserted mid-transaction (any state): on the next edge, all outputs take their reset values, held payloads are discarded, and no mem_we_o pulse is issued.
- mem_addr_o, mem_wdata_o and mem_wstrb_o hold their last values outside WRITE; only mem_we_o qualifies them.

## Test plan
- Aligned write, same-cycle AW/W: awaddr = 0x10, wdata = 0xDEADBEEF_CAFEF00D, wstrb = 0xFF at edge E -> mem_we_o = 1 in cycle E+1 with mem_addr_o = 2 and data/strobe matching; bvalid at E+2 with bresp = 00.
- W before AW, with B backpressure: W at cycle 3, AW at cycle 7, s_brdy_i held low for 5 cycles -> single write with mem_addr_o = awaddr>>3; wrdy stays 0 after the W handshake; bvalid and bresp stay stable for all 5 cycles; readies return on the B handshake edge.
- Out of range: awaddr = MEM_DEPTH*8 (0x8000) -> mem_we_o never asserted; bresp = 10.
- Partial and zero strobes: wstrb = 0x0F -> mem_wstrb_o = 0x0F; wstrb = 0x00 -> no mem_we_o, bresp = 00. Unaligned awaddr = 0x13 -> mem_addr_o = 2.
- Reset mid-RESP: assert s_arstn_i low while bvalid = 1 -> the next edge gives bvalid = 0 and readies = 0; after release, a fresh write (awaddr = 0x0) completes normally and no stale write occurs.
- Back-to-back: 10 random in-range writes with valids held high and brdy = 1 -> exactly 10 mem_we_o pulses, in order, each 4 cycles apart, all bresp = 00.
